npc_core: RTL and testbench

- Single-cycle RV32I integer core, top-level CPU of the NPC simulation platform.
- Fetches over a ready/valid instruction port and accesses data memory through a combinational-read, clocked-write port.
- Retires at most one instruction per clock.
- The simulation wrapper detects ebreak (0x00100073) on the fetch bus and reads a0 from the register file to report the trap code.

---
 rtl/npc_pkg.sv | 80 ++++++++
 rtl/npc_cpu.sv | 141 ++++++++++++++
 rtl/npc_regfile.sv | 49 ++++
 rtl/npc_core.sv | 42 ++++
 tb/tb_npc_core.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared types, opcodes and helper functions for the NPC RV32I
//               core.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  // funct3 selects the operation; alt (instr[30]) picks SUB/SRA variants
  function automatic alu_op_e alu_from_funct3(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(alu_op_e op, logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_SLL:    r = a << b[4:0];
      ALU_SLT:    r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   r = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    r = a ^ b;
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = $signed(a) >>> b[4:0];
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      default:    r = b;
    endcase
    return r;
  endfunction

  // Immediate extraction from the instruction bits above the opcode
  function automatic logic [XLEN-1:0] imm_gen(imm_type_e t, logic [31:7] ins);
    logic [XLEN-1:0] imm;
    case (t)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_cpu.sv
`default_nettype none
// ============================================================================
// Module      : npc_cpu
// Description : Single-cycle RV32I datapath: decode, immediates, ALU, branch
//               and PC logic, with the register file as instance REG.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_cpu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_ready_o,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [2:0]      dmem_wop_o,
  output logic            dmem_wen_o,
  output logic [XLEN-1:0] dmem_addr_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ready_q;
  logic            fire;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, op_a, op_b, alu_res, pc_plus4, wb_data;

  imm_type_e imm_type;
  alu_op_e   alu_op;
  logic      a_is_pc, b_is_imm, rd_we, is_load, is_store, is_branch, is_jal, is_jalr;
  logic      br_taken;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign fire   = ready_q & instr_valid_i;

  // Main decoder: anything not listed (SYSTEM, FENCE, unknown) is a no-op
  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    a_is_pc   = 1'b0;
    b_is_imm  = 1'b1;
    rd_we     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_COPY_B; rd_we = 1'b1; end
      OPC_AUIPC:  begin imm_type = IMM_U; a_is_pc = 1'b1; rd_we = 1'b1; end
      OPC_JAL:    begin imm_type = IMM_J; a_is_pc = 1'b1; rd_we = 1'b1; is_jal = 1'b1; end
      OPC_JALR:   begin rd_we = 1'b1; is_jalr = 1'b1; end
      OPC_BRANCH: begin imm_type = IMM_B; a_is_pc = 1'b1; is_branch = 1'b1; end
      OPC_LOAD:   begin rd_we = 1'b1; is_load = 1'b1; end
      OPC_STORE:  begin imm_type = IMM_S; is_store = 1'b1; end
      OPC_OP_IMM: begin
        rd_we  = 1'b1;
        // instr[30] is an immediate bit except for the SRAI/SRLI pair
        alu_op = alu_from_funct3(f3, instr_i[30] & (f3 == 3'd5));
      end
      OPC_OP:     begin
        rd_we    = 1'b1;
        b_is_imm = 1'b0;
        alu_op   = alu_from_funct3(f3, instr_i[30]);
      end
      default:    ;
    endcase
  end

  // Branch comparator works on register values; the ALU forms the target
  always_comb begin
    case (f3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    br_taken = (rs1_val <  rs2_val);
      3'd7:    br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign imm      = imm_gen(imm_type, instr_i[31:7]);
  assign op_a     = a_is_pc ? pc_q : rs1_val;
  assign op_b     = b_is_imm ? imm : rs2_val;
  assign alu_res  = alu_eval(alu_op, op_a, op_b);
  assign pc_plus4 = pc_q + 32'd4;

  // Next PC and write-back selection
  always_comb begin
    pc_d = pc_plus4;
    if (is_jal || (is_branch && br_taken)) pc_d = alu_res;
    else if (is_jalr)                      pc_d = alu_res & ~32'd1;
    wb_data = alu_res;
    if (is_load)                wb_data = dmem_rdata_i;
    else if (is_jal || is_jalr) wb_data = pc_plus4;
  end

  // PC advances only on a retiring handshake; ready rises on the first edge out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_VECTOR;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (fire) pc_q <= pc_d;
    end
  end

  npc_regfile REG (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_val),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_val),
    .we_i      (fire & rd_we),
    .waddr_i   (rd),
    .wdata_i   (wb_data)
  );

  assign pc_o          = pc_q;
  assign instr_ready_o = ready_q;
  assign dmem_addr_o   = alu_res;
  assign dmem_wdata_o  = rs2_val;
  assign dmem_wop_o    = f3;
  assign dmem_wen_o    = fire & is_store;

endmodule
`default_nettype wire

// File: rtl/npc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : npc_regfile
// Description : 32 x XLEN integer register file, two async reads, one
//               clocked write, x0 hard-wired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_regfile
  import npc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] rf_view [32];
  // a0 tap probed by the simulation wrapper to report the trap code
  logic [XLEN-1:0] gpr_10;

  assign gpr_10 = regs_q[10];

  // Read view: x0 forced to zero, a0 served through the same tap the wrapper sees
  always_comb begin
    rf_view     = regs_q;
    rf_view[0]  = '0;
    rf_view[10] = gpr_10;
  end

  assign rdata_a_o = rf_view[raddr_a_i];
  assign rdata_b_o = rf_view[raddr_b_i];

  // Clocked write port; writes to x0 are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/npc_core.sv
`default_nettype none
// ============================================================================
// Module      : npc_core
// Description : Top-level CPU of the NPC simulation platform; maps the
//               platform bus names onto the datapath instance riscv_cpu.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_core #(
  parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] io_Imem_raddr,
  output logic            io_Imem_rdata_ready,
  input  logic            io_Imem_rdata_valid,
  input  logic [31:0]     io_Imem_rdata_bits,
  input  logic [XLEN-1:0] io_Dmem_rdata,
  output logic [XLEN-1:0] io_Dmem_wdata,
  output logic [2:0]      io_Dmem_wop,
  output logic            io_Dmem_wen,
  output logic [XLEN-1:0] io_Dmem_wraddr
);

  npc_cpu #(
    .RESET_VECTOR (RESET_PC)
  ) riscv_cpu (
    .clk_i         (clock),
    .rst_ni        (reset),
    .pc_o          (io_Imem_raddr),
    .instr_ready_o (io_Imem_rdata_ready),
    .instr_valid_i (io_Imem_rdata_valid),
    .instr_i       (io_Imem_rdata_bits),
    .dmem_rdata_i  (io_Dmem_rdata),
    .dmem_wdata_o  (io_Dmem_wdata),
    .dmem_wop_o    (io_Dmem_wop),
    .dmem_wen_o    (io_Dmem_wen),
    .dmem_addr_o   (io_Dmem_wraddr)
  );

endmodule
`default_nettype wire

// File: tb/tb_npc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_core
// Description : Self-checking bench for npc_core against an instruction-level
//               reference model (directed items plus random programs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_core;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] raddr, ibits, drdata, dwdata, wraddr;
  logic        ready, valid, wen;
  logic [2:0]  wop;

  always #5 clock = ~clock;

  npc_core dut (
    .clock               (clock),
    .reset               (reset),
    .io_Imem_raddr       (raddr),
    .io_Imem_rdata_ready (ready),
    .io_Imem_rdata_valid (valid),
    .io_Imem_rdata_bits  (ibits),
    .io_Dmem_rdata       (drdata),
    .io_Dmem_wdata       (dwdata),
    .io_Dmem_wop         (wop),
    .io_Dmem_wen         (wen),
    .io_Dmem_wraddr      (wraddr)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef enum int {
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ECALL, K_EBREAK, K_FENCE, K_CSR, K_BAD, K_NUM
  } kind_e;

  typedef struct {
    kind_e       k;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;     // effective immediate value (shift amount for shift-imm)
  } ins_t;

  // Reference architectural state
  logic [31:0] m_x [32];
  logic [31:0] m_pc;

  function automatic bit is_store(kind_e k);
    return (k == K_SB) || (k == K_SH) || (k == K_SW);
  endfunction

  function automatic bit is_load(kind_e k);
    return (k >= K_LB) && (k <= K_LHU);
  endfunction

  function automatic logic [2:0] f3_of(kind_e k);
    case (k)
      K_BNE, K_LH, K_SH, K_SLLI, K_SLL:          return 3'd1;
      K_LW, K_SW, K_SLTI, K_SLT:                 return 3'd2;
      K_SLTIU, K_SLTU:                           return 3'd3;
      K_BLT, K_LBU, K_XORI, K_XOR:               return 3'd4;
      K_BGE, K_LHU, K_SRLI, K_SRAI, K_SRL, K_SRA: return 3'd5;
      K_BLTU, K_ORI, K_OR:                       return 3'd6;
      K_BGEU, K_ANDI, K_AND:                     return 3'd7;
      default:                                   return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] encode(ins_t t);
    logic [31:0] i = t.imm;
    logic [2:0]  f = f3_of(t.k);
    logic [31:0] r = $urandom();
    case (t.k)
      K_LUI:   return {i[31:12], t.rd, 7'h37};
      K_AUIPC: return {i[31:12], t.rd, 7'h17};
      K_JAL:   return {i[20], i[10:1], i[11], i[19:12], t.rd, 7'h6f};
      K_JALR:  return {i[11:0], t.rs1, 3'd0, t.rd, 7'h67};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
               return {i[12], i[10:5], t.rs2, t.rs1, f, i[4:1], i[11], 7'h63};
      K_LB, K_LH, K_LW, K_LBU, K_LHU:
               return {i[11:0], t.rs1, f, t.rd, 7'h03};
      K_SB, K_SH, K_SW:
               return {i[11:5], t.rs2, t.rs1, f, i[4:0], 7'h23};
      K_SLLI, K_SRLI: return {7'h00, i[4:0], t.rs1, f, t.rd, 7'h13};
      K_SRAI:  return {7'h20, i[4:0], t.rs1, f, t.rd, 7'h13};
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI:
               return {i[11:0], t.rs1, f, t.rd, 7'h13};
      K_SUB, K_SRA: return {7'h20, t.rs2, t.rs1, f, t.rd, 7'h33};
      K_ADD, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_OR, K_AND:
               return {7'h00, t.rs2, t.rs1, f, t.rd, 7'h33};
      K_ECALL:  return 32'h0000_0073;
      K_EBREAK: return 32'h0010_0073;
      K_FENCE:  return 32'h0ff0_000f;
      K_CSR:    return {12'h300, t.rs1, 3'b001, t.rd, 7'h73};
      default:  return {r[31:7], 7'h7f};
    endcase
  endfunction

  // Instruction-level reference: one retired instruction updates m_x / m_pc
  task automatic model_exec(ins_t t, logic [31:0] ld);
    logic [31:0] a = m_x[t.rs1];
    logic [31:0] b = m_x[t.rs2];
    logic [31:0] i = t.imm;
    logic [31:0] res = 32'd0;
    logic [31:0] npc = m_pc + 32'd4;
    bit          wr = 1'b1;
    case (t.k)
      K_LUI:   res = i;
      K_AUIPC: res = m_pc + i;
      K_JAL:   begin res = m_pc + 32'd4; npc = m_pc + i; end
      K_JALR:  begin res = m_pc + 32'd4; npc = (a + i) & 32'hFFFF_FFFE; end
      K_BEQ:   begin wr = 0; if (a == b) npc = m_pc + i; end
      K_BNE:   begin wr = 0; if (a != b) npc = m_pc + i; end
      K_BLT:   begin wr = 0; if ($signed(a) <  $signed(b)) npc = m_pc + i; end
      K_BGE:   begin wr = 0; if ($signed(a) >= $signed(b)) npc = m_pc + i; end
      K_BLTU:  begin wr = 0; if (a <  b) npc = m_pc + i; end
      K_BGEU:  begin wr = 0; if (a >= b) npc = m_pc + i; end
      K_LB, K_LH, K_LW, K_LBU, K_LHU: res = ld;
      K_ADDI:  res = a + i;
      K_SLTI:  res = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
      K_SLTIU: res = (a < i) ? 32'd1 : 32'd0;
      K_XORI:  res = a ^ i;
      K_ORI:   res = a | i;
      K_ANDI:  res = a & i;
      K_SLLI:  res = a << i[4:0];
      K_SRLI:  res = a >> i[4:0];
      K_SRAI:  res = $signed(a) >>> i[4:0];
      K_ADD:   res = a + b;
      K_SUB:   res = a - b;
      K_SLL:   res = a << b[4:0];
      K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      K_XOR:   res = a ^ b;
      K_SRL:   res = a >> b[4:0];
      K_SRA:   res = $signed(a) >>> b[4:0];
      K_OR:    res = a | b;
      K_AND:   res = a & b;
      default: wr = 0;
    endcase
    if (wr && t.rd != 5'd0) m_x[t.rd] = res;
    m_pc = npc;
  endtask

  function automatic ins_t mk(kind_e k, int rd, int rs1, int rs2, logic [31:0] imm);
    ins_t t;
    t.k = k; t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.imm = imm;
    return t;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      3:       return 5'd3;
      4:       return 5'd10;
      default: return 5'd11;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t        t;
    logic [31:0] r = $urandom();
    t.k   = kind_e'($urandom_range(0, int'(K_NUM) - 1));
    t.rd  = pick_reg();
    t.rs1 = pick_reg();
    t.rs2 = pick_reg();
    case (t.k)
      K_LUI, K_AUIPC:           t.imm = {r[31:12], 12'b0};
      K_JAL:                    t.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
                                t.imm = {{19{r[12]}}, r[12:1], 1'b0};
      K_SLLI, K_SRLI, K_SRAI:   t.imm = {27'b0, r[4:0]};
      default:                  t.imm = {{20{r[11]}}, r[11:0]};
    endcase
    return t;
  endfunction

  // Present one instruction between edges, check the bus, then retire it
  task automatic apply(ins_t t, bit v, logic [31:0] ld);
    ibits  = encode(t);
    valid  = v;
    drdata = ld;
    #2;
    chk("raddr", raddr, m_pc);
    chk("ready", {31'b0, ready}, 32'd1);
    chk("wen", {31'b0, wen}, {31'b0, v && is_store(t.k)});
    if (is_load(t.k) || is_store(t.k)) begin
      chk("wraddr", wraddr, m_x[t.rs1] + t.imm);
      chk("wop", {29'b0, wop}, {29'b0, f3_of(t.k)});
      if (is_store(t.k)) chk("wdata", dwdata, m_x[t.rs2]);
    end
    @(posedge clock);
    if (v) model_exec(t, ld);
    #1;
    chk("gpr_10", dut.riscv_cpu.REG.gpr_10, m_x[10]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc = RST_PC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    valid  = 1'b0;
    ibits  = 32'h0000_0013;
    drdata = 32'd0;
    model_reset();

    // Reset held across a few edges
    repeat (3) @(posedge clock);
    #1;
    chk("rst_raddr", raddr, RST_PC);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_wen", {31'b0, wen}, 32'd0);
    chk("rst_a0", dut.riscv_cpu.REG.gpr_10, 32'd0);

    // Release: ready stays low until the next edge samples it
    reset = 1'b1;
    #2;
    chk("rel_ready", {31'b0, ready}, 32'd0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) apply(mk(K_SW, 0, 0, 10, 4), 1'b0, 32'd0);

    // ALU pair
    apply(mk(K_ADDI, 10, 0, 0, 5), 1'b1, 32'd0);
    apply(mk(K_ADD, 10, 10, 10, 0), 1'b1, 32'd0);
    chk("alu_a0", dut.riscv_cpu.REG.gpr_10, 32'd10);
    chk("alu_pc", raddr, 32'h8000_0008);

    // Store / load
    apply(mk(K_SW, 0, 0, 10, 4), 1'b1, 32'd0);
    apply(mk(K_LB, 11, 0, 0, 4), 1'b1, 32'hFFFF_FF80);
    apply(mk(K_SW, 0, 0, 11, 0), 1'b1, 32'd0);

    // Branch, jump, jalr with odd target
    apply(mk(K_BEQ, 0, 0, 0, 8), 1'b1, 32'd0);
    apply(mk(K_JAL, 1, 0, 0, -8), 1'b1, 32'd0);
    apply(mk(K_SW, 0, 0, 1, 0), 1'b1, 32'd0);
    apply(mk(K_LUI, 2, 0, 0, 32'h8000_0000), 1'b1, 32'd0);
    apply(mk(K_ADDI, 2, 2, 0, 32'h101), 1'b1, 32'd0);
    apply(mk(K_JALR, 3, 2, 0, 0), 1'b1, 32'd0);
    chk("jalr_pc", raddr, 32'h8000_0100);

    // x0 stays zero; ebreak is a plain no-op; stalled store has no effect
    apply(mk(K_ADDI, 0, 0, 0, 7), 1'b1, 32'd0);
    apply(mk(K_SW, 0, 0, 0, 0), 1'b1, 32'd0);
    apply(mk(K_EBREAK, 0, 0, 0, 0), 1'b1, 32'd0);
    apply(mk(K_SW, 0, 1, 3, 12), 1'b0, 32'd0);
    apply(mk(K_SW, 0, 1, 3, 12), 1'b1, 32'd0);

    // Random programs with random stalls
    for (int n = 0; n < 3000; n++) begin
      apply(rand_ins(), ($urandom_range(0, 99) < 85), $urandom());
    end

    // Asynchronous reset mid-cycle while a store is on the bus
    apply(mk(K_ADDI, 10, 0, 0, 77), 1'b1, 32'd0);
    ibits = encode(mk(K_SW, 0, 0, 10, 8));
    valid = 1'b1;
    #2;
    chk("pre_rst_wen", {31'b0, wen}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_wen", {31'b0, wen}, 32'd0);
    chk("async_raddr", raddr, RST_PC);
    chk("async_a0", dut.riscv_cpu.REG.gpr_10, 32'd0);
    chk("async_ready", {31'b0, ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
